// File: rtl/sync_buffer_pkg.sv
// Shared state encoding and defaults for the sensor sync buffer frame controller.
package sync_buffer_pkg;

   localparam int unsigned STATE_WD         = 3;
   localparam int unsigned FLUSH_CNT_WD     = 8;
   localparam int unsigned FLUSH_CYCLES_DEF = 8;

   localparam logic [STATE_WD-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_WD-1:0] ST_ARM    = 3'd1;
   localparam logic [STATE_WD-1:0] ST_WAIT   = 3'd2;
   localparam logic [STATE_WD-1:0] ST_ACTIVE = 3'd3;
   localparam logic [STATE_WD-1:0] ST_DROP   = 3'd4;
   localparam logic [STATE_WD-1:0] ST_FLUSH  = 3'd5;

   typedef enum logic [STATE_WD-1:0] {
      S_IDLE   = ST_IDLE,
      S_ARM    = ST_ARM,
      S_WAIT   = ST_WAIT,
      S_ACTIVE = ST_ACTIVE,
      S_DROP   = ST_DROP,
      S_FLUSH  = ST_FLUSH
   } state_t;

endpackage

// File: rtl/sync_buffer_ctrl_edge_detect.sv
// Registered-history rise/fall detector for a single-bit level.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise_c,
   output logic fall_c
);

   logic sig_d;

   // One-cycle history of the input level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_d <= 1'b0;
      else        sig_d <= sig;
   end

   assign rise_c = sig & ~sig_d;
   assign fall_c = ~sig & sig_d;

endmodule

// File: rtl/sync_buffer_ctrl.sv
// Admits or blocks whole sensor frames into the sync buffer, aborts and flushes
// on overflow, and keeps frame/drop/line statistics.
module sync_buffer_ctrl
   import sync_buffer_pkg::*;
#(
   parameter int unsigned REG_WD       = 32,
   parameter int unsigned LINE_CNT_WD  = 16,
   parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic                   clk_sensor_pix,
   input  logic                   reset_sensor_n,
   input  logic                   i_fval,
   input  logic                   i_lval,
   input  logic                   i_acquisition_start,
   input  logic                   i_stream_enable,
   input  logic                   i_encrypt_state,
   input  logic                   i_buf_overflow,
   output logic                   o_fval,
   output logic                   o_wr_en,
   output logic                   o_buf_reset,
   output logic                   o_frame_done,
   output logic [REG_WD-1:0]      ov_frame_cnt,
   output logic [REG_WD-1:0]      ov_drop_cnt,
   output logic [LINE_CNT_WD-1:0] ov_line_cnt
);

   state_t                  state;
   logic [LINE_CNT_WD-1:0]  line_cnt;
   logic [FLUSH_CNT_WD-1:0] flush_cnt;
   logic                    fval_rise;
   logic                    fval_fall;
   logic                    lval_rise;
   logic                    en;

   assign en = i_acquisition_start & i_stream_enable & i_encrypt_state;

   edge_detect u_fval_edge (
      .clk    (clk_sensor_pix),
      .rst_n  (reset_sensor_n),
      .sig    (i_fval),
      .rise_c (fval_rise),
      .fall_c (fval_fall)
   );

   edge_detect u_lval_edge (
      .clk    (clk_sensor_pix),
      .rst_n  (reset_sensor_n),
      .sig    (i_lval),
      .rise_c (lval_rise),
      .fall_c ()
   );

   // Frame admission FSM with registered gating outputs and statistics counters
   always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
      if (!reset_sensor_n) begin
         state        <= S_IDLE;
         line_cnt     <= '0;
         flush_cnt    <= '0;
         o_fval       <= 1'b0;
         o_wr_en      <= 1'b0;
         o_buf_reset  <= 1'b0;
         o_frame_done <= 1'b0;
         ov_frame_cnt <= '0;
         ov_drop_cnt  <= '0;
         ov_line_cnt  <= '0;
      end else begin
         o_frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               o_fval      <= 1'b0;
               o_wr_en     <= 1'b0;
               o_buf_reset <= 1'b0;
               if (en) state <= S_ARM;
            end
            // A frame already in flight is skipped: wait for fval low first
            S_ARM: begin
               o_fval  <= 1'b0;
               o_wr_en <= 1'b0;
               if (!en)         state <= S_IDLE;
               else if (!i_fval) state <= S_WAIT;
            end
            S_WAIT: begin
               o_fval  <= 1'b0;
               o_wr_en <= 1'b0;
               if (!en) begin
                  state <= S_IDLE;
               end else if (fval_rise) begin
                  state    <= S_ACTIVE;
                  o_fval   <= 1'b1;
                  o_wr_en  <= i_lval;
                  line_cnt <= LINE_CNT_WD'(lval_rise);
               end
            end
            // Enable drops do not truncate an admitted frame; overflow wins over fval fall
            S_ACTIVE: begin
               if (i_buf_overflow) begin
                  state       <= S_DROP;
                  o_fval      <= 1'b0;
                  o_wr_en     <= 1'b0;
                  ov_drop_cnt <= ov_drop_cnt + REG_WD'(1);
               end else if (fval_fall) begin
                  state        <= en ? S_WAIT : S_IDLE;
                  o_fval       <= 1'b0;
                  o_wr_en      <= i_lval;
                  o_frame_done <= 1'b1;
                  ov_frame_cnt <= ov_frame_cnt + REG_WD'(1);
                  ov_line_cnt  <= line_cnt;
               end else begin
                  o_fval  <= i_fval;
                  o_wr_en <= i_lval;
                  if (lval_rise && (line_cnt != '1))
                     line_cnt <= line_cnt + LINE_CNT_WD'(1);
               end
            end
            S_DROP: begin
               o_fval  <= 1'b0;
               o_wr_en <= 1'b0;
               if (!i_fval) begin
                  state       <= S_FLUSH;
                  o_buf_reset <= 1'b1;
                  flush_cnt   <= FLUSH_CNT_WD'(FLUSH_CYCLES - 1);
               end
            end
            S_FLUSH: begin
               if (flush_cnt == '0) begin
                  o_buf_reset <= 1'b0;
                  state       <= S_ARM;
               end else begin
                  flush_cnt <= flush_cnt - FLUSH_CNT_WD'(1);
               end
            end
            default: begin
               state       <= S_IDLE;
               o_fval      <= 1'b0;
               o_wr_en     <= 1'b0;
               o_buf_reset <= 1'b0;
            end
         endcase
      end
   end

endmodule
